trace_capture: RTL
==================

TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one probe channel.
REQ-002 SHALL have parameter CHANNELS, default 3, number of probe channels (1..8).
REQ-003 SHALL have parameter DEPTH, default 64, samples per channel; power of two, 4..1024.
REQ-004 SHALL have parameter PRE_TRIG, default 16, pre-trigger samples retained; 0..DEPTH-1.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: ports CLOCK_50 and reset.
REQ-006 CLOCK_50  input  1  capture and read clock.
REQ-007 reset  input  1  asynchronous active-low reset.
REQ-008 probe_data  input  CHANNELS*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
REQ-009 probe_valid  input  1  sample strobe; only cycles with probe_valid=1 are stored.
REQ-010 arm  input  1  single-cycle start pulse.
REQ-011 abort  input  1  return to IDLE, capture discarded.
REQ-012 trig_mode  input  1  0 = external trig_in, 1 = channel-0 value match.
REQ-013 trig_in  input  1  external trigger, sampled with probe_valid.
REQ-014 trig_value  input  DATA_W  match value for trig_mode=1.
REQ-015 rd_addr  input  log2(DEPTH)  sample index; 0 = oldest retained sample.
REQ-016 rd_chan  input  log2(CHANNELS) (min 1)  channel select.
REQ-017 rd_data  output  DATA_W  registered read data.
REQ-018 state  output  3  FSM state encoding.
REQ-019 done  output  1  high while in DONE.
REQ-020 trig_pos  output  log2(DEPTH)  rd_addr of the trigger sample (equals PRE_TRIG).

Function
REQ-021 FSM states SHALL be IDLE=0, PREFILL=1, WAIT_TRIG=2, POST=3, DONE=4.
REQ-022 IDLE -> PREFILL on arm; if PRE_TRIG=0, IDLE -> WAIT_TRIG directly.
REQ-023 PREFILL: each valid sample written at wr_ptr, wr_ptr+1 mod DEPTH; after PRE_TRIG samples -> WAIT_TRIG.
REQ-024 Triggers during PREFILL SHALL be ignored; the sample is still stored.
REQ-025 WAIT_TRIG: each valid sample written circularly (wraps, overwriting oldest); trigger hit = probe_valid & (trig_mode ? ch0==trig_value : trig_in).
REQ-026 On hit: trigger sample stored, trig_ptr latched to its write address, post counter loaded with DEPTH-PRE_TRIG-1, -> POST (-> DONE directly if that count is 0).
REQ-027 POST: each valid sample stored and counter decremented; storing with counter 1 -> DONE same edge.
REQ-028 Total stored = DEPTH exactly: PRE_TRIG before trigger, trigger, DEPTH-PRE_TRIG-1 after.
REQ-029 DONE: no writes; holds until arm (-> PREFILL, new capture) or abort.
REQ-030 abort in any state -> IDLE next edge; abort wins over simultaneous arm and over trigger.
REQ-031 arm in PREFILL, WAIT_TRIG or POST SHALL be ignored.
REQ-032 Physical read address = (trig_ptr - PRE_TRIG + rd_addr) mod DEPTH; rd_data valid one cycle after rd_addr/rd_chan.
REQ-033 Reads permitted in any state; contents defined only in DONE.
REQ-034 probe_valid=0 cycles SHALL not advance pointers or counters.
REQ-035 Storage SHALL be one DEPTH x DATA_W array per channel, inferable as block RAM.

Reset
REQ-036 On reset low: state=IDLE, done=0, rd_data=0, wr_ptr=0, trig_ptr=0, counters=0; memory contents not cleared.
REQ-037 Reset asserted mid-capture SHALL abandon the capture; after release the block waits for arm.

Verification
REQ-038 Default params, arm, ch0 counts 0,1,2... each cycle, trig_mode=1, trig_value=40 -> done after sample 87; rd_addr 0..63 ch0 returns 24..87; trig_pos=16.
REQ-039 trig_mode=0, trig_in pulsed at sample 5 (inside PREFILL) then at sample 30 -> first ignored; rd_addr 16 ch0 = 30.
REQ-040 probe_valid toggling 1,0 with trigger at sample 100 -> same buffer contents as continuous run; DONE reached after 47 further valid samples.
REQ-041 abort asserted in POST together with arm -> state=IDLE next cycle, done=0; later arm restarts in PREFILL.
REQ-042 PRE_TRIG=0, DEPTH=4, CHANNELS=1 -> trigger sample at rd_addr 0, done after 3 more samples; PRE_TRIG=3 -> done on trigger edge.
REQ-043 reset low during WAIT_TRIG -> all outputs at reset values immediately (asynchronous), no DONE without new arm.

Source files
------------

// File: rtl/trace_capture.sv
`default_nettype none
// ============================================================================
// trace_capture : multi-channel logic-analyser capture with pre/post trigger.
// Rev 1.0
// ============================================================================
module trace_capture #(
  parameter int DATA_W   = 32,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 64,
  parameter int PRE_TRIG = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic [CHANNELS*DATA_W-1:0] probe_data,
  input  logic                       probe_valid,
  input  logic                       arm,
  input  logic                       abort,
  input  logic                       trig_mode,
  input  logic                       trig_in,
  input  logic [DATA_W-1:0]          trig_value,
  input  logic [AW-1:0]              rd_addr,
  input  logic [CW-1:0]              rd_chan,
  output logic [DATA_W-1:0]          rd_data,
  output logic [2:0]                 state,
  output logic                       done,
  output logic [AW-1:0]              trig_pos
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PREFILL = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_POST    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [AW-1:0] PRE_LEN  = AW'(PRE_TRIG);
  localparam logic [AW-1:0] POST_LEN = AW'(DEPTH - PRE_TRIG - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] trig_ptr_q, trig_ptr_d;
  logic [AW-1:0] pre_cnt_q, pre_cnt_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [CW-1:0] rd_chan_q, rd_chan_d;
  logic          rd_vld_q, rd_vld_d;

  logic              trig_hit;
  logic              wr_en;
  logic              done_w;
  logic [AW-1:0]     rd_phys;
  logic [DATA_W-1:0] rd_words [CHANNELS];

  assign trig_hit = probe_valid &
                    (trig_mode ? (probe_data[DATA_W-1:0] == trig_value) : trig_in);

  // rd_addr is relative to the oldest retained sample, PRE_TRIG before the trigger.
  assign rd_phys = trig_ptr_q - PRE_LEN + rd_addr;

  // State and control registers
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      trig_ptr_q <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      rd_chan_q  <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      trig_ptr_q <= trig_ptr_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      rd_chan_q  <= rd_chan_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  // Next-state and pointer/counter update
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    trig_ptr_d = trig_ptr_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    rd_chan_d  = rd_chan;
    rd_vld_d   = 1'b1;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            wr_ptr_d  = '0;
            pre_cnt_d = PRE_LEN;
            state_d   = (PRE_TRIG == 0) ? ST_WAIT : ST_PREFILL;
          end
        end
        ST_PREFILL: begin
          if (probe_valid) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            pre_cnt_d = pre_cnt_q - 1'b1;
            if (pre_cnt_q == AW'(1)) state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (probe_valid) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (trig_hit) begin
              trig_ptr_d = wr_ptr_q;
              post_cnt_d = POST_LEN;
              state_d    = (POST_LEN == '0) ? ST_DONE : ST_POST;
            end
          end
        end
        ST_POST: begin
          if (probe_valid) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            post_cnt_d = post_cnt_q - 1'b1;
            if (post_cnt_q == AW'(1)) state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    done_w = (state_q == ST_DONE);
    wr_en  = probe_valid & ~abort &
             ((state_q == ST_PREFILL) | (state_q == ST_WAIT) | (state_q == ST_POST));
    rd_data = '0;
    if (rd_vld_q) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (rd_chan_q == CW'(k)) rd_data = rd_words[k];
      end
    end
  end

  assign state    = state_q;
  assign done     = done_w;
  assign trig_pos = PRE_LEN;

  // One simple dual-port array per channel with a registered read port.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word_q;

    always_ff @(posedge CLOCK_50) begin
      if (wr_en) mem[wr_ptr_q] <= probe_data[k*DATA_W +: DATA_W];
      rd_word_q <= mem[rd_phys];
    end

    assign rd_words[k] = rd_word_q;
  end

endmodule
`default_nettype wire
